muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit with architectural HI/LO registers.
- Replaces the single-cycle combinational multiplier in the 5-stage pipeline's EXE stage; adds signed/unsigned divide and MTHI/MTLO.
- Talks to the pipeline controller through a start/busy/done handshake. The controller holds EXE and earlier stages while busy=1.

Parameters:
- WIDTH, 32, operand and HI/LO width; must be even and >= 4.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- start  in  1  request; sampled only when busy=0
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 no-op
- a  in  WIDTH  operand A (multiplicand/dividend/MT source)
- b  in  WIDTH  operand B (multiplier/divisor)
- cancel  in  1  pipeline flush; aborts operation in flight
- busy  out  1  operation in progress; controller stalls on it
- done  out  1  one-cycle pulse when HI/LO updated by mul/div
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset (rst=1 at edge): state IDLE, busy=0, done=0, hi=0, lo=0, counter=0. Reset overrides start and cancel, including mid-operation.
- States:
  - IDLE: on start with op 000–011, latch operands and transition to CALC.
    - Signed ops store operand magnitudes plus the result-sign flags.
  - CALC: WIDTH cycles, one shift-add (mul) or restoring shift-subtract (div) step per cycle; counter counts 0..WIDTH-1.
  - FIX: one cycle.
    - Apply sign correction.
    - Write hi/lo at the end of FIX.
    - done=1 in the following cycle, together with the return to IDLE.
- busy=1 in CALC and FIX; busy=0 in IDLE.
- Latency: start sampled at edge k → new hi/lo and done=1 visible after edge k+WIDTH+1 (WIDTH+2 edges including the accept edge), for exactly one cycle.
- Back-to-back: start may be accepted in the cycle where done=1 (busy=0 then).
- start while busy=1 is ignored; the controller guarantees it holds start until busy=0.
- MTHI/MTLO:
  - Accepted in IDLE only; hi (or lo) := a at the accept edge.
  - busy stays 0, done not asserted; other register unchanged.
- op 110/111: no effect.
- Multiply: {hi,lo} = full 2*WIDTH product. MULT is two's complement, MULTU is unsigned.
- Divide: lo = quotient, hi = remainder.
  - DIV truncates toward zero; remainder takes the dividend's sign.
  - Divide by zero (b=0), both DIV and DIVU: lo = all ones, hi = a. Completes with normal latency.
  - DIV overflow (a = most negative, b = -1): lo = a, hi = 0.
- cancel=1 in CALC or FIX: return to IDLE at that edge, hi/lo unchanged, done not asserted.
  - cancel in IDLE is ignored.
  - cancel and start together in IDLE: start wins.
- hi/lo change only on: reset, MTHI/MTLO accept, FIX completion.

Optional Feature:
- MULDIV_FAST_MUL_EN
  - Defined: MULT/MULTU complete combinationally.
    - State IDLE→FIX directly.
    - done visible after edge k+1, busy=1 for one cycle.
  - Divide unchanged.
  - Undefined: multiply uses the iterative WIDTH-cycle path above.

Test Plan:
- WIDTH=32, MULT a=0xFFFFFFFD (-3), b=5 → after 34 cycles done=1, hi=0xFFFFFFFF, lo=0xFFFFFFF1; busy=1 for exactly 33 cycles.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. DIVU a=100, b=7 → lo=14, hi=2.
- DIV a=0xFFFFFFF9 (-7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU a=0x1234, b=0 → lo=0xFFFFFFFF, hi=0x00001234, normal latency.
  - Then MTHI a=0xABCD in the done cycle → hi=0xABCD next cycle, lo unchanged, no done pulse.
- Start DIV, assert cancel at cycle 10 → busy=0 next cycle, hi/lo hold prior values, no done.
  - Repeat with rst at cycle 10 → hi=lo=0, busy=0.
- With MULDIV_FAST_MUL_EN: MULT 6×7 → done after 2 edges, lo=42, hi=0; DIVU latency still 34.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers and a start/busy/done handshake.
// Define MULDIV_FAST_MUL_EN to complete MULT/MULTU in a single combinational step.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;
    logic               rem_neg_q, rem_neg_d;
    logic               dz_q, dz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic               signed_op, is_mul_op, is_div_op, a_neg, b_neg;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] prod_mag, prod_res;
    logic [WIDTH-1:0]   res_hi, res_lo;

    assign signed_op = ~op[0];
    assign is_mul_op = (op[2:1] == 2'b00);
    assign is_div_op = (op[2:1] == 2'b01);
    assign a_neg     = signed_op & a[WIDTH-1];
    assign b_neg     = signed_op & b[WIDTH-1];
    assign mag_a     = a_neg ? -a : a;
    assign mag_b     = b_neg ? -b : b;

`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] fast_prod;
    assign fast_prod = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
`endif

    // Multiply: rem holds the running upper half, quo shifts out multiplier bits.
    assign mul_sum   = {1'b0, rem_q} + (quo_q[0] ? {1'b0, opb_q} : {(WIDTH + 1){1'b0}});
    // Divide: restoring step, a set top bit of the difference means "does not fit".
    assign div_shift = {rem_q, quo_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opb_q};

    assign prod_mag  = {rem_q, quo_q};
    assign prod_res  = neg_q ? -prod_mag : prod_mag;

    always_comb begin
        res_hi = prod_res[2*WIDTH-1:WIDTH];
        res_lo = prod_res[WIDTH-1:0];
        if (dz_q) begin
            res_hi = a_q;
            res_lo = '1;
        end else if (is_div_q) begin
            res_hi = rem_neg_q ? -rem_q : rem_q;
            res_lo = neg_q ? -quo_q : quo_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        opb_d     = opb_q;
        a_d       = a_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        dz_d      = dz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (is_mul_op || is_div_op) begin
                        state_d   = StCalc;
                        cnt_d     = '0;
                        rem_d     = '0;
                        a_d       = a;
                        is_div_d  = is_div_op;
                        neg_d     = a_neg ^ b_neg;
                        rem_neg_d = a_neg;
                        dz_d      = is_div_op && (b == '0);
                        if (is_div_op) begin
                            opb_d = mag_b;
                            quo_d = mag_a;
                        end else begin
                            opb_d = mag_a;
                            quo_d = mag_b;
`ifdef MULDIV_FAST_MUL_EN
                            {rem_d, quo_d} = fast_prod;
                            state_d        = StFix;
`endif
                        end
                    end else if (op == 3'b100) begin
                        hi_d = a;
                    end else if (op == 3'b101) begin
                        lo_d = a;
                    end
                end
            end
            StCalc: begin
                if (cancel) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (is_div_q) begin
                        if (!div_diff[WIDTH]) begin
                            rem_d = div_diff[WIDTH-1:0];
                            quo_d = {quo_q[WIDTH-2:0], 1'b1};
                        end else begin
                            rem_d = div_shift[WIDTH-1:0];
                            quo_d = {quo_q[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        rem_d = mul_sum[WIDTH:1];
                        quo_d = {mul_sum[0], quo_q[WIDTH-1:1]};
                    end
                    if (cnt_q == CntLast) begin
                        state_d = StFix;
                    end
                end
            end
            StFix: begin
                state_d = StIdle;
                if (!cancel) begin
                    hi_d   = res_hi;
                    lo_d   = res_lo;
                    done_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            opb_q     <= '0;
            a_q       <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            opb_q     <= opb_d;
            a_q       <= a_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            dz_q      <= dz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign busy = (state_q != StIdle);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: arithmetic reference model checked every cycle, plus directed literal checks.
module tb_muldiv_unit;

    localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    logic         clk = 1'b0;
    logic         rst, start, cancel, busy, done;
    logic [2:0]   op;
    logic [W-1:0] a, b, hi, lo;

    int total = 0;
    int bad   = 0;

    muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .cancel(cancel),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
        end
    endtask

    // Reference model: architectural result plus a busy-cycle countdown.
    int          rem_cyc = 0;
    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    bit          m_done = 1'b0;
    bit          checking = 1'b0;

    function automatic int lat(input logic [2:0] o);
        return (FAST && o[2:1] == 2'b00) ? 1 : W + 1;
    endfunction

    task automatic calc(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] h, output logic [31:0] l);
        int          sx, sy;
        longint      sp;
        logic [63:0] up;
        sx = x;
        sy = y;
        h  = '0;
        l  = '0;
        if (o == OP_MULT) begin
            sp     = longint'(sx) * longint'(sy);
            {h, l} = sp;
        end else if (o == OP_MULTU) begin
            up     = {32'b0, x} * {32'b0, y};
            {h, l} = up;
        end else if (y == 0) begin
            h = x;
            l = '1;
        end else if (o == OP_DIV) begin
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                h = '0;
                l = x;
            end else begin
                l = sx / sy;
                h = sx % sy;
            end
        end else begin
            l = x / y;
            h = x % y;
        end
    endtask

    always @(posedge clk) begin
        m_done = 1'b0;
        if (rst) begin
            rem_cyc = 0;
            m_hi    = '0;
            m_lo    = '0;
        end else if (rem_cyc > 0) begin
            if (cancel) begin
                rem_cyc = 0;
            end else begin
                rem_cyc--;
                if (rem_cyc == 0) begin
                    m_hi   = p_hi;
                    m_lo   = p_lo;
                    m_done = 1'b1;
                end
            end
        end else if (start) begin
            if (op[2] == 1'b0) begin
                calc(op, a, b, p_hi, p_lo);
                rem_cyc = lat(op);
            end else if (op == OP_MTHI) begin
                m_hi = a;
            end else if (op == OP_MTLO) begin
                m_lo = a;
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            chk("cyc_busy", busy, rem_cyc > 0);
            chk("cyc_done", done, m_done);
            chk("cyc_hi", hi, m_hi);
            chk("cyc_lo", lo, m_lo);
        end
    end

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic c);
        op     = o;
        a      = x;
        b      = y;
        cancel = c;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        cancel = 1'b0;
    endtask

    task automatic wait_done(output bit seen, output int nbusy);
        seen  = 1'b0;
        nbusy = 0;
        for (int i = 0; i < 100; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) nbusy++;
            @(negedge clk);
        end
    endtask

    task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic c,
                          input logic [31:0] eh, input logic [31:0] el);
        bit seen;
        int n;
        issue(o, x, y, c);
        wait_done(seen, n);
        chk({name, "_done"}, seen, 1);
        chk({name, "_hi"}, hi, eh);
        chk({name, "_lo"}, lo, el);
        chk({name, "_busycyc"}, n, lat(o));
    endtask

    task automatic count_done(input string name, input int cycles);
        int d = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (done) d++;
        end
        chk(name, d, 0);
    endtask

    initial begin
        bit seen;
        int n;
        rst    = 1'b1;
        start  = 1'b0;
        cancel = 1'b0;
        op     = '0;
        a      = '0;
        b      = '0;
        repeat (2) @(negedge clk);
        rst      = 1'b0;
        checking = 1'b1;
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);

        run_op("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd5, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0,
               32'hFFFF_FFFE, 32'h0000_0001);
        run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 1'b0, 32'd2, 32'd14);
        run_op("div_neg7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h8000_0000);
        run_op("divu_dz", OP_DIVU, 32'h1234, 32'h0, 1'b0, 32'h0000_1234, 32'hFFFF_FFFF);

        // MTHI accepted in the done cycle.
        issue(OP_MTHI, 32'hABCD, 32'h0, 1'b0);
        chk("mthi_hi", hi, 32'hABCD);
        chk("mthi_lo", lo, 32'hFFFF_FFFF);
        chk("mthi_done", done, 0);
        chk("mthi_busy", busy, 0);

        issue(OP_MTLO, 32'h5555, 32'h0, 1'b0);
        chk("mtlo_lo", lo, 32'h5555);
        chk("mtlo_hi", hi, 32'hABCD);

        issue(3'b110, 32'h1, 32'h2, 1'b0);
        chk("nop_hi", hi, 32'hABCD);
        chk("nop_lo", lo, 32'h5555);
        chk("nop_busy", busy, 0);

        run_op("div_dz_neg", OP_DIV, 32'hFFFF_FFF9, 32'h0, 1'b0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
        run_op("div_7_neg2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 1'b0, 32'd1, 32'hFFFF_FFFD);
        run_op("mult_6_7", OP_MULT, 32'd6, 32'd7, 1'b0, 32'd0, 32'd42);

        // Cancel ten cycles into a divide.
        issue(OP_DIV, 32'd100, 32'd3, 1'b0);
        repeat (9) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        chk("cancel_busy", busy, 0);
        chk("cancel_hi", hi, 32'd0);
        chk("cancel_lo", lo, 32'd42);
        count_done("cancel_nodone", 40);

        // Cancel landing on the final (sign-fix) cycle.
        issue(OP_DIVU, 32'd50, 32'd3, 1'b0);
        repeat (32) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        chk("cancelfix_busy", busy, 0);
        chk("cancelfix_lo", lo, 32'd42);
        count_done("cancelfix_nodone", 5);

        run_op("start_wins", OP_DIVU, 32'd50, 32'd3, 1'b1, 32'd2, 32'd16);

        // A start while busy must be ignored.
        issue(OP_DIVU, 32'd9, 32'd2, 1'b0);
        repeat (4) @(negedge clk);
        op    = OP_MTHI;
        a     = 32'hFFFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(seen, n);
        chk("busystart_done", seen, 1);
        chk("busystart_hi", hi, 32'd1);
        chk("busystart_lo", lo, 32'd4);

        // Reset mid-operation.
        issue(OP_DIV, 32'd100, 32'd3, 1'b0);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_hi", hi, 0);
        chk("midrst_lo", lo, 0);
        chk("midrst_busy", busy, 0);
        count_done("midrst_nodone", 40);

        checking = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
